// File: rtl/piso_shift_register.sv
// piso_shift_register: valid/ready word in, framed serial bits out; PISO_PARITY_EN appends an even parity bit
module piso_shift_register #(
  parameter int WIDTH = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic last, accept, first_bit, next_bit;
  logic [WIDTH-1:0] load_sh, sr_sh;
  // handshake and next-bit selection; sr holds the bits not yet presented
  always_comb begin
    last = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
`ifdef PISO_PARITY_EN
    load_ready = !rst && (state == IDLE || state == PARITY);
`else
    load_ready = !rst && (state == IDLE || last);
`endif
    accept = load_valid && load_ready;
    first_bit = MSB_FIRST ? parallel_in[WIDTH-1] : parallel_in[0];
    next_bit = MSB_FIRST ? sr[WIDTH-1] : sr[0];
    load_sh = MSB_FIRST ? {parallel_in[WIDTH-2:0], 1'b0} : {1'b0, parallel_in[WIDTH-1:1]};
    sr_sh = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
    busy = state != IDLE;
  end
  // frame sequencer with registered serial outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
      serial_out <= 1'b0;
      serial_valid <= 1'b0;
      frame_start <= 1'b0;
`ifdef PISO_PARITY_EN
      par <= 1'b0;
`endif
    end else if (accept) begin
      state <= SHIFT;
      sr <= load_sh;
      cnt <= '0;
      serial_out <= first_bit;
      serial_valid <= 1'b1;
      frame_start <= 1'b1;
`ifdef PISO_PARITY_EN
      par <= ^parallel_in;
`endif
    end else if (state == SHIFT && !last) begin
      sr <= sr_sh;
      cnt <= cnt + CW'(1);
      serial_out <= next_bit;
      frame_start <= 1'b0;
`ifdef PISO_PARITY_EN
    end else if (last) begin
      state <= PARITY;
      cnt <= cnt + CW'(1);
      serial_out <= par;
      frame_start <= 1'b0;
`endif
    end else begin
      state <= IDLE;
      serial_out <= 1'b0;
      serial_valid <= 1'b0;
      frame_start <= 1'b0;
    end
  end
endmodule

// File: tb/tb_piso_shift_register.sv
// tb_piso_shift_register: queue-based reference check of MSB-first and LSB-first instances
module tb_piso_shift_register;
  typedef struct packed {logic b; logic s;} ent_t;
  logic clk = 0, rst = 0, lv = 0;
  logic [3:0] pin = '0;
  logic rdy_m, out_m, val_m, fs_m, busy_m;
  logic rdy_l, out_l, val_l, fs_l, busy_l;
  ent_t qm[$], ql[$];
  int vectors = 0, errors = 0, idx = 0;
  logic [3:0] rx_m = '0, rx_l = '0;

  piso_shift_register #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(lv), .parallel_in(pin), .load_ready(rdy_m),
    .serial_out(out_m), .serial_valid(val_m), .frame_start(fs_m), .busy(busy_m));
  piso_shift_register #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(lv), .parallel_in(pin), .load_ready(rdy_l),
    .serial_out(out_l), .serial_valid(val_l), .frame_start(fs_l), .busy(busy_l));

  always #5 clk = ~clk;

  task automatic push_frame(input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      qm.push_back({w[3-i], i == 0});
      ql.push_back({w[i], i == 0});
    end
`ifdef PISO_PARITY_EN
    qm.push_back({^w, 1'b0});
    ql.push_back({^w, 1'b0});
`endif
  endtask

  task automatic cycle(input logic v, input logic [3:0] d, input logic r);
    logic exp_rdy;
    logic [3:0] em, el;
    lv = v; pin = d; rst = r;
    #1;
    exp_rdy = !r && qm.size() <= 1;
    vectors++;
    if (rdy_m !== exp_rdy) begin errors++; $display("FAIL ready_msb got %b want %b t=%0t", rdy_m, exp_rdy, $time); end
    vectors++;
    if (rdy_l !== exp_rdy) begin errors++; $display("FAIL ready_lsb got %b want %b t=%0t", rdy_l, exp_rdy, $time); end
    @(posedge clk);
    if (r) begin
      qm.delete(); ql.delete();
    end else begin
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (v && exp_rdy) push_frame(d);
    end
    #1;
    em = qm.size() > 0 ? {qm[0].b, 1'b1, qm[0].s, 1'b1} : 4'b0000;
    el = ql.size() > 0 ? {ql[0].b, 1'b1, ql[0].s, 1'b1} : 4'b0000;
    vectors++;
    if ({out_m, val_m, fs_m, busy_m} !== em) begin errors++; $display("FAIL out_msb {out,valid,start,busy} got %b want %b t=%0t", {out_m, val_m, fs_m, busy_m}, em, $time); end
    vectors++;
    if ({out_l, val_l, fs_l, busy_l} !== el) begin errors++; $display("FAIL out_lsb {out,valid,start,busy} got %b want %b t=%0t", {out_l, val_l, fs_l, busy_l}, el, $time); end
    if (val_l && fs_l) idx = 0;
    if (val_l && idx < 4) begin rx_l[idx] = out_l; rx_m[3-idx] = out_m; idx++; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom), 1'b0);
  endtask

  task automatic test_reset;
    cycle(1'b1, 4'b1010, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    idle(2);
  endtask

  task automatic test_single;
    cycle(1'b1, 4'b1011, 1'b0);
    idle(6);
  endtask

  task automatic test_back_to_back;
    cycle(1'b1, 4'b1011, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'b0110, 1'b0);
    idle(8);
  endtask

  task automatic test_reset_midframe;
    cycle(1'b1, 4'b1111, 1'b0);
    idle(1);
    cycle(1'b0, 4'b0000, 1'b1);
    idle(1);
    cycle(1'b1, 4'b0001, 1'b0);
    idle(6);
  endtask

  task automatic test_busy_ignore;
    cycle(1'b1, 4'b1100, 1'b0);
    cycle(1'b0, 4'b0000, 1'b0);
    cycle(1'b1, 4'b0011, 1'b0);
    idle(6);
  endtask

  task automatic test_sipo_loopback;
    rx_m = '0; rx_l = '0; idx = 0;
    cycle(1'b1, 4'b1011, 1'b0);
    idle(6);
    vectors++;
    if (rx_l !== 4'b1011) begin errors++; $display("FAIL sipo_lsb got %b want 1011", rx_l); end
    vectors++;
    if (rx_m !== 4'b1011) begin errors++; $display("FAIL sipo_msb got %b want 1011", rx_m); end
  endtask

  task automatic test_parity_words;
    cycle(1'b1, 4'b1011, 1'b0);
    idle(6);
    cycle(1'b1, 4'b1001, 1'b0);
    idle(6);
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom_range(0, 39) == 0));
    idle(8);
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_reset_midframe;
    test_busy_ignore;
    test_sipo_loopback;
    test_parity_words;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
